// File: rtl/blood_mon_pkg.sv
// Shared types and defaults for the blood level monitor.
// Holds the alarm FSM encoding, threshold defaults and sum width helper.
package blood_mon_pkg;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_NORMAL,
    ST_PENDING,
    ST_ALARM,
    ST_RECOVER
  } state_e;

  localparam int          DEF_WIN_LOG2 = 2;
  localparam logic [7:0]  DEF_HIGH_TH  = 8'd100;
  localparam logic [7:0]  DEF_LOW_TH   = 8'd80;
  localparam int          DEF_HOLD_CNT = 3;

  // A sum of 2^w bytes never exceeds 8+w bits.
  function automatic int sum_w(input int win_log2);
    return 8 + win_log2;
  endfunction

endpackage

// File: rtl/blood_level_monitor_window.sv
// Moving-average window: shift register, running sum, fill counter.
// Ports: clk, rst, clear, sample_valid, abs_level -> avg_valid, avg_level, window_full.
module moving_avg_window
  import blood_mon_pkg::*;
#(
  parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       sample_valid,
  input  logic [7:0] abs_level,
  output logic       avg_valid,
  output logic [7:0] avg_level,
  output logic       window_full
);

  localparam int N  = 1 << WIN_LOG2;
  localparam int SW = sum_w(WIN_LOG2);
  localparam int CW = WIN_LOG2 + 1;

  logic [N-1:0][7:0] win_q, win_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic              avg_valid_q;
  logic [7:0]        avg_q;
  logic              full_q;

  always_comb begin
    // Wraparound is safe: the true result is a sum of N bytes.
    sum_d  = sum_q + SW'(abs_level) - SW'(win_q[N-1]);
    win_d  = {win_q[N-2:0], abs_level};
    fill_d = (fill_q == CW'(N)) ? fill_q : fill_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      win_q       <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      avg_valid_q <= 1'b0;
      avg_q       <= 8'd0;
      full_q      <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      if (sample_valid) begin
        win_q  <= win_d;
        sum_q  <= sum_d;
        fill_q <= fill_d;
        full_q <= (fill_d == CW'(N));
        if (fill_d == CW'(N)) begin
          avg_valid_q <= 1'b1;
          avg_q       <= sum_d[SW-1:WIN_LOG2];
        end
      end
    end
  end

  assign avg_valid   = avg_valid_q;
  assign avg_level   = avg_q;
  assign window_full = full_q;

endmodule

// File: rtl/blood_level_monitor.sv
// Blood level monitor: moving average plus debounced hysteresis alarm.
// Ports: clk, rst, clear, sample_valid, abs_level -> avg_valid, avg_level,
// window_full, alarm, peak_level. Macro BLOOD_MON_PEAK_EN enables peak_level.
module blood_level_monitor
  import blood_mon_pkg::*;
#(
  parameter int         WIN_LOG2 = DEF_WIN_LOG2,
  parameter logic [7:0] HIGH_TH  = DEF_HIGH_TH,
  parameter logic [7:0] LOW_TH   = DEF_LOW_TH,
  parameter int         HOLD_CNT = DEF_HOLD_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       sample_valid,
  input  logic [7:0] abs_level,
  output logic       avg_valid,
  output logic [7:0] avg_level,
  output logic       window_full,
  output logic       alarm,
  output logic [7:0] peak_level
);

  localparam logic [3:0] HOLD = 4'(HOLD_CNT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       alarm_q, alarm_d;
  logic       hi, lo;

  moving_avg_window #(
    .WIN_LOG2(WIN_LOG2)
  ) u_win (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .sample_valid(sample_valid),
    .abs_level   (abs_level),
    .avg_valid   (avg_valid),
    .avg_level   (avg_level),
    .window_full (window_full)
  );

  assign hi = avg_level > HIGH_TH;
  assign lo = avg_level < LOW_TH;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (avg_valid) begin
      unique case (state_q)
        ST_FILL: begin
          if (window_full) state_d = ST_NORMAL;
        end
        ST_NORMAL: begin
          if (hi) begin
            cnt_d   = (HOLD == 4'd1) ? 4'd0 : 4'd1;
            state_d = (HOLD == 4'd1) ? ST_ALARM : ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (!hi) begin
            cnt_d   = 4'd0;
            state_d = ST_NORMAL;
          end else if (cnt_q + 4'd1 == HOLD) begin
            cnt_d   = 4'd0;
            state_d = ST_ALARM;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_ALARM: begin
          if (lo) begin
            cnt_d   = (HOLD == 4'd1) ? 4'd0 : 4'd1;
            state_d = (HOLD == 4'd1) ? ST_NORMAL : ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (!lo) begin
            cnt_d   = 4'd0;
            state_d = ST_ALARM;
          end else if (cnt_q + 4'd1 == HOLD) begin
            cnt_d   = 4'd0;
            state_d = ST_NORMAL;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          cnt_d   = 4'd0;
          state_d = ST_FILL;
        end
      endcase
    end
    // Registered from next state so alarm tracks the state glitch-free.
    alarm_d = (state_d == ST_ALARM) || (state_d == ST_RECOVER);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= ST_FILL;
      cnt_q   <= 4'd0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;

`ifdef BLOOD_MON_PEAK_EN
  logic [7:0] peak_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      peak_q <= 8'd0;
    end else if (sample_valid && abs_level > peak_q) begin
      peak_q <= abs_level;
    end
  end

  assign peak_level = peak_q;
`else
  assign peak_level = 8'd0;
`endif

endmodule
